sc_max7219_rx: RTL and testbench

SC_MAX7219_RX -- requirements
Module: sc_max7219_rx

---
 rtl/sc_max7219_rx_pkg.sv | 31 +++
 rtl/sc_max7219_rx_if.sv | 35 +++
 rtl/sc_max7219_rx_sync_edge.sv | 20 ++
 rtl/sc_max7219_rx.sv | 127 ++++++++++++
 tb/tb_sc_max7219_rx.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/sc_max7219_rx_pkg.sv
// sc_max7219_rx_pkg: shared FSM encoding, MAX7219 register map and frame length.
package sc_max7219_rx_pkg;

    localparam int FRAME_BITS = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } stateT;

    typedef enum logic [3:0] {
        ADDR_NOOP        = 4'h0,
        ADDR_DIGIT0      = 4'h1,
        ADDR_DIGIT1      = 4'h2,
        ADDR_DIGIT2      = 4'h3,
        ADDR_DIGIT3      = 4'h4,
        ADDR_DIGIT4      = 4'h5,
        ADDR_DIGIT5      = 4'h6,
        ADDR_DIGIT6      = 4'h7,
        ADDR_DIGIT7      = 4'h8,
        ADDR_DECODEMODE  = 4'h9,
        ADDR_INTENSITY   = 4'hA,
        ADDR_SCANLIMIT   = 4'hB,
        ADDR_SHUTDOWN    = 4'hC,
        ADDR_RESERVED_D  = 4'hD,
        ADDR_RESERVED_E  = 4'hE,
        ADDR_DISPLAYTEST = 4'hF
    } regAddrT;

endpackage

// File: rtl/sc_max7219_rx_if.sv
// sc_max7219_rx_if: serial pins, row read port and decoded register outputs.
interface sc_max7219_rx_if #(
    parameter int DATAWIDTH_BUS = 8
);
    logic                     SC_MAX7219_RX_max7219DIN_In;
    logic                     SC_MAX7219_RX_max7219NCS_In;
    logic                     SC_MAX7219_RX_max7219CLK_In;
    logic [2:0]               SC_MAX7219_RX_RowAddr_InBus;
    logic [DATAWIDTH_BUS-1:0] SC_MAX7219_RX_RowData_OutBus;
    logic [3:0]               SC_MAX7219_RX_Intensity_OutBus;
    logic [2:0]               SC_MAX7219_RX_ScanLimit_OutBus;
    logic [DATAWIDTH_BUS-1:0] SC_MAX7219_RX_DecodeMode_OutBus;
    logic                     SC_MAX7219_RX_Shutdown_Out;
    logic                     SC_MAX7219_RX_DisplayTest_Out;
    logic                     SC_MAX7219_RX_FrameValid_Out;
    logic                     SC_MAX7219_RX_FrameError_Out;

    modport master (
        output SC_MAX7219_RX_max7219DIN_In, SC_MAX7219_RX_max7219NCS_In,
               SC_MAX7219_RX_max7219CLK_In, SC_MAX7219_RX_RowAddr_InBus,
        input  SC_MAX7219_RX_RowData_OutBus, SC_MAX7219_RX_Intensity_OutBus,
               SC_MAX7219_RX_ScanLimit_OutBus, SC_MAX7219_RX_DecodeMode_OutBus,
               SC_MAX7219_RX_Shutdown_Out, SC_MAX7219_RX_DisplayTest_Out,
               SC_MAX7219_RX_FrameValid_Out, SC_MAX7219_RX_FrameError_Out
    );

    modport slave (
        input  SC_MAX7219_RX_max7219DIN_In, SC_MAX7219_RX_max7219NCS_In,
               SC_MAX7219_RX_max7219CLK_In, SC_MAX7219_RX_RowAddr_InBus,
        output SC_MAX7219_RX_RowData_OutBus, SC_MAX7219_RX_Intensity_OutBus,
               SC_MAX7219_RX_ScanLimit_OutBus, SC_MAX7219_RX_DecodeMode_OutBus,
               SC_MAX7219_RX_Shutdown_Out, SC_MAX7219_RX_DisplayTest_Out,
               SC_MAX7219_RX_FrameValid_Out, SC_MAX7219_RX_FrameError_Out
    );
endinterface

// File: rtl/sc_max7219_rx_sync_edge.sv
// sc_sync_edge: 2-flop synchronizer plus a third flop for rise/fall detection.
module sc_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstN,
    input  logic asyncIn,
    output logic syncOut,
    output logic rise,
    output logic fall
);
    logic [2:0] sync;

    always_ff @(posedge clk)
        sync <= !rstN ? {3{RESET_VAL}} : {sync[1:0], asyncIn};

    assign syncOut = sync[1];
    assign rise    = sync[1] & ~sync[2];
    assign fall    = ~sync[1] & sync[2];
endmodule

// File: rtl/sc_max7219_rx.sv
// sc_max7219_rx: MAX7219-compatible serial receiver decoding frames into the
// digit RAM and control registers.
module sc_max7219_rx
    import sc_max7219_rx_pkg::*;
#(
    parameter int DATAWIDTH_BUS = 8,
    parameter int FRAME_BITS    = sc_max7219_rx_pkg::FRAME_BITS
) (
    input logic SC_MAX7219_RX_CLOCK_50,
    input logic SC_MAX7219_RX_RESET_InLow,
    sc_max7219_rx_if.slave bus
);
    localparam int CNT_W = $clog2(FRAME_BITS + 1);

    logic clk, rstN;
    logic din, dinRise, dinFall;
    logic ncsSync, ncsRise, ncsFall;
    logic clkSync, clkRise, clkFall;
    stateT state, stateNext;
    logic [FRAME_BITS-1:0] shiftReg;
    logic [CNT_W-1:0] bitCnt;
    logic [DATAWIDTH_BUS-1:0] rows [8];
    logic [DATAWIDTH_BUS-1:0] rowData, decodeMode;
    logic [3:0] intensity, addr;
    logic [2:0] scanLimit;
    logic shutdown, displayTest, frameValid, frameError;
    logic frameDone, shiftEn, clearCnt, commit, shortFrame;
    logic unusedSig;

    assign clk  = SC_MAX7219_RX_CLOCK_50;
    assign rstN = SC_MAX7219_RX_RESET_InLow;

    sc_sync_edge #(.RESET_VAL(1'b0)) dinSyncEdge (
        .clk(clk), .rstN(rstN), .asyncIn(bus.SC_MAX7219_RX_max7219DIN_In),
        .syncOut(din), .rise(dinRise), .fall(dinFall)
    );
    sc_sync_edge #(.RESET_VAL(1'b1)) ncsSyncEdge (
        .clk(clk), .rstN(rstN), .asyncIn(bus.SC_MAX7219_RX_max7219NCS_In),
        .syncOut(ncsSync), .rise(ncsRise), .fall(ncsFall)
    );
    sc_sync_edge #(.RESET_VAL(1'b0)) clkSyncEdge (
        .clk(clk), .rstN(rstN), .asyncIn(bus.SC_MAX7219_RX_max7219CLK_In),
        .syncOut(clkSync), .rise(clkRise), .fall(clkFall)
    );

    assign frameDone = bitCnt == CNT_W'(FRAME_BITS);
    assign addr      = shiftReg[11:8];

    always_ff @(posedge clk)
        state <= !rstN ? IDLE : stateNext;

    // NCS edges win over a coincident CLK edge, so the closing edge never shifts
    always_comb begin
        stateNext  = state;
        shiftEn    = 1'b0;
        clearCnt   = 1'b0;
        commit     = 1'b0;
        shortFrame = 1'b0;
        case (state)
            IDLE: begin
                stateNext = ncsFall ? SHIFT : IDLE;
                clearCnt  = ncsFall;
            end
            SHIFT: begin
                stateNext  = ncsRise ? (frameDone ? COMMIT : IDLE) : SHIFT;
                shiftEn    = clkRise && !ncsRise;
                shortFrame = ncsRise && !frameDone;
            end
            COMMIT: begin
                stateNext = ncsFall ? SHIFT : IDLE;
                clearCnt  = ncsFall;
                commit    = 1'b1;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            shiftReg    <= '0;
            bitCnt      <= '0;
            rows        <= '{default: '0};
            rowData     <= '0;
            decodeMode  <= '0;
            intensity   <= '0;
            scanLimit   <= '0;
            shutdown    <= 1'b1;
            displayTest <= 1'b0;
            frameValid  <= 1'b0;
            frameError  <= 1'b0;
        end else begin
            frameValid <= commit;
            frameError <= shortFrame;
            rowData    <= rows[bus.SC_MAX7219_RX_RowAddr_InBus];
            if (clearCnt)
                bitCnt <= '0;
            else if (shiftEn) begin
                shiftReg <= {shiftReg[FRAME_BITS-2:0], din};
                bitCnt   <= frameDone ? bitCnt : bitCnt + 1'b1;
            end
            if (commit)
                case (regAddrT'(addr))
                    ADDR_DIGIT0, ADDR_DIGIT1, ADDR_DIGIT2, ADDR_DIGIT3,
                    ADDR_DIGIT4, ADDR_DIGIT5, ADDR_DIGIT6, ADDR_DIGIT7:
                        rows[3'(addr - 4'd1)] <= shiftReg[DATAWIDTH_BUS-1:0];
                    ADDR_DECODEMODE:  decodeMode  <= shiftReg[DATAWIDTH_BUS-1:0];
                    ADDR_INTENSITY:   intensity   <= shiftReg[3:0];
                    ADDR_SCANLIMIT:   scanLimit   <= shiftReg[2:0];
                    ADDR_SHUTDOWN:    shutdown    <= ~shiftReg[0];
                    ADDR_DISPLAYTEST: displayTest <= shiftReg[0];
                    ADDR_NOOP, ADDR_RESERVED_D, ADDR_RESERVED_E: ;
                    default: ;
                endcase
        end
    end

    assign unusedSig = ^{shiftReg[FRAME_BITS-1:12], dinRise, dinFall, ncsSync, clkSync, clkFall};

    assign bus.SC_MAX7219_RX_RowData_OutBus    = rowData;
    assign bus.SC_MAX7219_RX_DecodeMode_OutBus = decodeMode;
    assign bus.SC_MAX7219_RX_Intensity_OutBus  = intensity;
    assign bus.SC_MAX7219_RX_ScanLimit_OutBus  = scanLimit;
    assign bus.SC_MAX7219_RX_Shutdown_Out      = shutdown;
    assign bus.SC_MAX7219_RX_DisplayTest_Out   = displayTest;
    assign bus.SC_MAX7219_RX_FrameValid_Out    = frameValid;
    assign bus.SC_MAX7219_RX_FrameError_Out    = frameError;
endmodule

// File: tb/tb_sc_max7219_rx.sv
// tb_sc_max7219_rx: directed and random MAX7219 frames checked against a
// register-map model of the chip.
module tb_sc_max7219_rx;
    logic clk = 1'b0;
    logic rstN = 1'b0;
    always #10 clk = ~clk;

    sc_max7219_rx_if bus ();

    sc_max7219_rx dut (
        .SC_MAX7219_RX_CLOCK_50(clk),
        .SC_MAX7219_RX_RESET_InLow(rstN),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int fvCnt = 0;
    int feCnt = 0;

    always @(posedge clk) begin
        if (bus.SC_MAX7219_RX_FrameValid_Out) fvCnt++;
        if (bus.SC_MAX7219_RX_FrameError_Out) feCnt++;
    end

    logic [7:0] mRows [8];
    logic [7:0] mDec;
    logic [3:0] mInt;
    logic [2:0] mScan;
    logic mShut, mDt;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        foreach (mRows[i]) mRows[i] = 8'h00;
        mDec = 8'h00; mInt = 4'h0; mScan = 3'h0; mShut = 1'b1; mDt = 1'b0;
    endtask

    // Only the last 16 bits of a frame of at least 16 bits count
    task automatic modelFrame(input logic [31:0] v, input int n, output bit ok);
        logic [15:0] f;
        int a;
        ok = n >= 16;
        f = v[15:0];
        a = int'(f[11:8]);
        if (ok) begin
            if (a >= 1 && a <= 8) mRows[a-1] = f[7:0];
            else if (a == 9)  mDec  = f[7:0];
            else if (a == 10) mInt  = f[3:0];
            else if (a == 11) mScan = f[2:0];
            else if (a == 12) mShut = !f[0];
            else if (a == 15) mDt   = f[0];
        end
    endtask

    task automatic sendBits(input logic [31:0] v, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            bus.SC_MAX7219_RX_max7219DIN_In = v[i];
            cyc(4);
            bus.SC_MAX7219_RX_max7219CLK_In = 1'b1;
            cyc(4);
            bus.SC_MAX7219_RX_max7219CLK_In = 1'b0;
        end
    endtask

    task automatic sendFrame(input logic [31:0] v, input int n, input int gap, input bit clash);
        bus.SC_MAX7219_RX_max7219NCS_In = 1'b0;
        cyc(4);
        sendBits(v, n - 1, 0);
        cyc(4);
        if (clash) begin
            bus.SC_MAX7219_RX_max7219DIN_In = 1'($urandom);
            bus.SC_MAX7219_RX_max7219CLK_In = 1'b1;
        end
        bus.SC_MAX7219_RX_max7219NCS_In = 1'b1;
        cyc(gap);
        bus.SC_MAX7219_RX_max7219CLK_In = 1'b0;
    endtask

    task automatic checkRegs(input string tag);
        chk({tag, "_intensity"}, 32'(bus.SC_MAX7219_RX_Intensity_OutBus), 32'(mInt));
        chk({tag, "_scanlimit"}, 32'(bus.SC_MAX7219_RX_ScanLimit_OutBus), 32'(mScan));
        chk({tag, "_decode"}, 32'(bus.SC_MAX7219_RX_DecodeMode_OutBus), 32'(mDec));
        chk({tag, "_shutdown"}, 32'(bus.SC_MAX7219_RX_Shutdown_Out), 32'(mShut));
        chk({tag, "_disptest"}, 32'(bus.SC_MAX7219_RX_DisplayTest_Out), 32'(mDt));
    endtask

    task automatic checkRows(input string tag);
        for (int a = 0; a < 8; a++) begin
            bus.SC_MAX7219_RX_RowAddr_InBus = 3'(a);
            cyc(1);
            chk($sformatf("%s_row%0d", tag, a), 32'(bus.SC_MAX7219_RX_RowData_OutBus), 32'(mRows[a]));
        end
    endtask

    task automatic expectFrame(input string tag, input logic [31:0] v, input int n, input bit clash);
        int fv0, fe0;
        bit ok;
        fv0 = fvCnt;
        fe0 = feCnt;
        sendFrame(v, n, 12, clash);
        modelFrame(v, n, ok);
        chk({tag, "_valid"}, 32'(fvCnt - fv0), 32'(ok));
        chk({tag, "_error"}, 32'(feCnt - fe0), 32'(!ok));
        checkRegs(tag);
    endtask

    initial begin
        int fv0, fe0, lat, n, r;
        bit ok;
        logic [31:0] v;
        bus.SC_MAX7219_RX_max7219DIN_In = 1'b0;
        bus.SC_MAX7219_RX_max7219NCS_In = 1'b1;
        bus.SC_MAX7219_RX_max7219CLK_In = 1'b0;
        bus.SC_MAX7219_RX_RowAddr_InBus = 3'd0;
        modelReset();
        cyc(4);
        rstN = 1'b1;
        cyc(3);
        chk("rst_valid", 32'(bus.SC_MAX7219_RX_FrameValid_Out), 32'd0);
        chk("rst_error", 32'(bus.SC_MAX7219_RX_FrameError_Out), 32'd0);
        chk("rst_rowdata", 32'(bus.SC_MAX7219_RX_RowData_OutBus), 32'd0);
        checkRegs("rst");
        checkRows("rst");

        // Intensity frame, with NCS-to-FrameValid latency measured
        fv0 = fvCnt; fe0 = feCnt; lat = 0;
        sendFrame(32'h0A05, 16, 0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            cyc(1);
            if (bus.SC_MAX7219_RX_FrameValid_Out && lat == 0) lat = k;
        end
        modelFrame(32'h0A05, 16, ok);
        chk("int_latency_ok", 32'(lat >= 3 && lat <= 5), 32'd1);
        chk("int_valid", 32'(fvCnt - fv0), 32'd1);
        chk("int_error", 32'(feCnt - fe0), 32'd0);
        checkRegs("int");

        expectFrame("shut", 32'h0C01, 16, 1'b0);
        expectFrame("row2", 32'h0381, 16, 1'b0);
        checkRows("row2");
        expectFrame("short", $urandom, 10, 1'b0);
        checkRows("short");
        expectFrame("daisy", 32'hFF0B06, 24, 1'b0);
        expectFrame("clash", 32'h0A09, 16, 1'b1);
        expectFrame("noop", 32'h00AA, 16, 1'b0);
        expectFrame("resd", 32'h0D3C, 16, 1'b0);

        // Back-to-back with 2-cycle gap, then a 1-cycle gap landing in COMMIT
        fv0 = fvCnt;
        sendFrame(32'h08F0, 16, 2, 1'b0);
        sendFrame(32'h0F01, 16, 12, 1'b0);
        modelFrame(32'h08F0, 16, ok);
        modelFrame(32'h0F01, 16, ok);
        chk("b2b_valid", 32'(fvCnt - fv0), 32'd2);
        checkRegs("b2b");
        fv0 = fvCnt;
        sendFrame(32'h0155, 16, 1, 1'b0);
        sendFrame(32'h0B03, 16, 12, 1'b0);
        modelFrame(32'h0155, 16, ok);
        modelFrame(32'h0B03, 16, ok);
        chk("gap1_valid", 32'(fvCnt - fv0), 32'd2);
        checkRegs("gap1");
        checkRows("gap");

        // Reset in the middle of a frame, then finish the frame
        fv0 = fvCnt;
        bus.SC_MAX7219_RX_max7219NCS_In = 1'b0;
        cyc(4);
        sendBits(32'h0155, 15, 8);
        rstN = 1'b0;
        cyc(3);
        rstN = 1'b1;
        modelReset();
        checkRegs("midrst");
        sendBits(32'h0155, 7, 0);
        cyc(4);
        bus.SC_MAX7219_RX_max7219NCS_In = 1'b1;
        cyc(12);
        chk("midrst_valid", 32'(fvCnt - fv0), 32'd0);
        checkRegs("midrst_end");
        checkRows("midrst");

        for (int it = 0; it < 24; it++) begin
            r = int'($urandom_range(0, 9));
            n = r < 7 ? 16 : (r < 8 ? int'($urandom_range(17, 24)) : int'($urandom_range(1, 15)));
            v = $urandom;
            expectFrame($sformatf("rand%0d", it), v, n, 1'b0);
        end
        checkRows("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
